wb_pwm: RTL and testbench
=========================

WB_PWM -- requirements
Module: wb_pwm

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; bits [31:8] are decoded.
REQ-002 SHALL have parameter CNT_W, default 16, counter/period/duty width (legal range 2..32).
REQ-003 SHALL have port wb_clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone classic strobe, cycle and write enable.
REQ-006 SHALL have port wbs_sel_i  input  4  byte lane selects.
REQ-007 SHALL have ports wbs_adr_i, wbs_dat_i  input  32 each  address and write data.
REQ-008 SHALL have port wbs_ack_o  output  1  transfer acknowledge.
REQ-009 SHALL have port wbs_dat_o  output  32  read data.
REQ-010 SHALL have port pwm_o  output  1  PWM waveform, intended for an mprj_io pad.
REQ-011 SHALL have port pwm_oeb_o  output  1  pad output-enable-bar, 0 when CTRL.EN=1, else 1.
REQ-012 SHALL have port irq_o  output  1  period-end interrupt; constant 0 when the interrupt feature is compiled out.

Function
REQ-013 SHALL decode the register map: 0x00 CTRL (RW, [0] EN, [1] POL, [2] IRQ_EN); 0x04 PERIOD (RW); 0x08 DUTY (RW); 0x0C COUNT (RO); 0x10 STATUS (bit0 WRAP, W1C).
REQ-014 SHALL select a transfer when stb&cyc=1 and wbs_adr_i[31:8]==BASE_ADDR[31:8]; unselected transfers receive no ack.
REQ-015 SHALL assert wbs_ack_o exactly one cycle after a selected transfer is first seen, for one cycle only, and SHALL NOT re-ack while that ack is high (ack period of 2 cycles for a held strobe).
REQ-016 SHALL present read data on wbs_dat_o in the ack cycle, zero-extended; wbs_dat_o SHALL be 0 when ack is low.
REQ-017 SHALL apply writes only on lanes with wbs_sel_i set; unmapped offsets within the window SHALL ack, read 0, ignore writes.
REQ-018 PERIOD and DUTY writes SHALL update shadow registers; the active copies SHALL load from shadow at counter wrap, or on every cycle while EN=0.
REQ-019 While EN=1 the counter SHALL increment by 1 per cycle and wrap from active PERIOD to 0, giving a PWM period of PERIOD+1 cycles.
REQ-020 pwm_o SHALL be registered and equal (count < active DUTY) XOR POL, one cycle after the count value it reflects.
REQ-021 DUTY=0 SHALL give constant inactive level (POL); DUTY>PERIOD SHALL give constant active level; PERIOD=0 SHALL hold the count at 0 and wrap every cycle.
REQ-022 When EN=0 the counter SHALL hold 0 and pwm_o SHALL equal POL; EN 0->1 SHALL start counting from 0 on the next cycle.
REQ-023 A write to PERIOD that coincides with a wrap SHALL load the new value on the following wrap, not the current one.
REQ-024 COUNT reads SHALL return the counter value at the cycle the transfer is first seen.

Reset
REQ-025 On wb_rst_ni low, SHALL immediately clear all registers, counter, STATUS; outputs: wbs_ack_o=0, wbs_dat_o=0, pwm_o=0, pwm_oeb_o=1, irq_o=0.
REQ-026 Reset asserted mid-transfer SHALL abort it with no ack and no register update; release SHALL be synchronous to wb_clk_i by the integrating design.

Configuration
REQ-027 With macro PWM_IRQ_EN defined, STATUS.WRAP SHALL set on every counter wrap while EN=1, clear on writing 1 (set wins over simultaneous clear), and irq_o SHALL be registered WRAP AND IRQ_EN.
REQ-028 Without PWM_IRQ_EN, STATUS and CTRL[2] SHALL read 0, writes to them SHALL be ignored, irq_o SHALL be tied 0, and no related flops SHALL exist.

Verification
REQ-029 Reset, read all five offsets -> each reads 0, ack 1 cycle after strobe, pwm_oeb_o=1.
REQ-030 PERIOD=9, DUTY=3, CTRL=0x1 -> pwm_o high 3, low 7 cycles, repeating every 10 cycles; pwm_oeb_o=0.
REQ-031 Running PERIOD=9/DUTY=3, write DUTY=8 mid-period -> current period keeps 3 high cycles, next period shows 8.
REQ-032 DUTY=0 then DUTY=20 with PERIOD=9, POL=1 -> pwm_o constant 1, then constant 0.
REQ-033 PWM_IRQ_EN defined, CTRL=0x5, PERIOD=4 -> irq_o rises 1 cycle after first wrap; write STATUS=1 -> irq_o falls, re-rises 5 cycles later.
REQ-034 Access at BASE_ADDR+0x100 -> no ack for 10 cycles, no register change; reset pulsed mid-run -> pwm_o=0, COUNT=0 immediately.

Source files
------------

// File: rtl/wb_pwm.sv
// wb_pwm: Wishbone classic slave driving one PWM channel with shadowed
// PERIOD/DUTY registers that take effect at the counter wrap.
// Optional period-end interrupt (STATUS.WRAP, irq_o) built only when
// the macro PWM_IRQ_EN is defined; otherwise irq_o is tied low.
// Ports:
//   wb_clk_i, wb_rst_ni   clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i  Wishbone strobe, cycle, write enable
//   wbs_sel_i[3:0]        byte lane selects
//   wbs_adr_i, wbs_dat_i  address, write data
//   wbs_ack_o, wbs_dat_o  acknowledge, read data (0 outside ack)
//   pwm_o, pwm_oeb_o      PWM waveform and pad output-enable-bar
//   irq_o                 period-end interrupt
module wb_pwm #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        pwm_o,
    output logic        pwm_oeb_o,
    output logic        irq_o
);

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_PERIOD = 8'h04;
    localparam logic [7:0] OFF_DUTY   = 8'h08;
    localparam logic [7:0] OFF_COUNT  = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;

    logic             ack_q;
    logic [31:0]      dat_q;
    logic             en_q;
    logic             pol_q;
    logic             irq_en;
    logic             status_rd;
    logic [CNT_W-1:0] per_sh;
    logic [CNT_W-1:0] duty_sh;
    logic [CNT_W-1:0] per_act;
    logic [CNT_W-1:0] duty_act;
    logic [CNT_W-1:0] cnt_q;
    logic             pwm_q;

    logic             sel;
    logic             acc;
    logic             wr;
    logic [7:0]       off;
    logic [31:0]      wmask;
    logic [31:0]      rdata;
    logic             is_ctrl;
    logic             is_per;
    logic             is_duty;
    logic             is_cnt;
    logic             is_stat;
    logic             wr_ctrl;
    logic             wr_per;
    logic             wr_duty;
    logic             wrap;

    // Byte-lane merge of a write into a CNT_W-wide register.
    function automatic logic [CNT_W-1:0] merge(
        input logic [CNT_W-1:0] old,
        input logic [31:0]      dat,
        input logic [31:0]      msk
    );
        merge = CNT_W'((32'(old) & ~msk) | (dat & msk));
    endfunction

    assign sel = wbs_stb_i & wbs_cyc_i &
                 (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // A held strobe is only accepted while ack is low, so every
    // accepted transfer gets exactly one ack one cycle later.
    assign acc = sel & ~ack_q;
    assign wr  = acc & wbs_we_i;
    assign off = wbs_adr_i[7:0];

    assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                    {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    assign is_ctrl = (off == OFF_CTRL);
    assign is_per  = (off == OFF_PERIOD);
    assign is_duty = (off == OFF_DUTY);
    assign is_cnt  = (off == OFF_COUNT);
    assign is_stat = (off == OFF_STATUS);

    assign wr_ctrl = wr & is_ctrl & wbs_sel_i[0];
    assign wr_per  = wr & is_per;
    assign wr_duty = wr & is_duty;

    assign wrap = en_q & (cnt_q == per_act);

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            is_ctrl: rdata = {29'b0, irq_en, pol_q, en_q};
            is_per:  rdata = 32'(per_sh);
            is_duty: rdata = 32'(duty_sh);
            is_cnt:  rdata = 32'(cnt_q);
            is_stat: rdata = {31'b0, status_rd};
            default: rdata = '0;
        endcase
    end

    // Read data is latched when the transfer is first seen and is
    // forced to zero in every cycle without an ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= acc;
            dat_q <= (acc & ~wbs_we_i) ? rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            en_q    <= 1'b0;
            pol_q   <= 1'b0;
            per_sh  <= '0;
            duty_sh <= '0;
        end else begin
            if (wr_ctrl) begin
                en_q  <= wbs_dat_i[0];
                pol_q <= wbs_dat_i[1];
            end
            if (wr_per) begin
                per_sh <= merge(per_sh, wbs_dat_i, wmask);
            end
            if (wr_duty) begin
                duty_sh <= merge(duty_sh, wbs_dat_i, wmask);
            end
        end
    end

    // Active copies follow the shadows while idle and otherwise only
    // at a wrap; a shadow write landing on the wrap edge is therefore
    // picked up one period later.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q    <= '0;
            per_act  <= '0;
            duty_act <= '0;
            pwm_q    <= 1'b0;
        end else begin
            if (!en_q || wrap) begin
                cnt_q    <= '0;
                per_act  <= per_sh;
                duty_act <= duty_sh;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            pwm_q <= en_q ? ((cnt_q < duty_act) ^ pol_q) : pol_q;
        end
    end

`ifdef PWM_IRQ_EN
    logic irq_en_q;
    logic wrap_q;
    logic irq_q;
    logic wr_stat;
    logic wrap_d;
    logic irq_en_d;

    assign wr_stat  = wr & is_stat & wbs_sel_i[0] & wbs_dat_i[0];
    // Set beats a simultaneous write-one-to-clear.
    assign wrap_d   = wrap | (wrap_q & ~wr_stat);
    assign irq_en_d = wr_ctrl ? wbs_dat_i[2] : irq_en_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_en_q <= 1'b0;
            wrap_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            wrap_q   <= wrap_d;
            irq_q    <= wrap_d & irq_en_d;
        end
    end

    assign irq_en    = irq_en_q;
    assign status_rd = wrap_q;
    assign irq_o     = irq_q;
`else
    assign irq_en    = 1'b0;
    assign status_rd = 1'b0;
    assign irq_o     = 1'b0;
`endif

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign pwm_o     = pwm_q;
    assign pwm_oeb_o = ~en_q;

endmodule

// File: tb/tb_wb_pwm.sv
// tb_wb_pwm: randomized self-checking bench for wb_pwm.
// Expected waveforms are generated period by period from the register rules.
module tb_wb_pwm;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] O_CTRL = 32'h00;
    localparam logic [31:0] O_PER  = 32'h04;
    localparam logic [31:0] O_DUTY = 32'h08;
    localparam logic [31:0] O_CNT  = 32'h0C;
    localparam logic [31:0] O_STAT = 32'h10;

    logic        clk;
    logic        rst_n;
    logic        stb_i;
    logic        cyc_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic        ack;
    logic [31:0] dat_r;
    logic        pwm;
    logic        oeb;
    logic        irq;

    int          tests;
    int          fails;
    int          ncyc;
    int          last_cyc;
    int          last_lat;
    logic [31:0] last_rd;
    int          ecnt [256];
    int          eduty [256];

    wb_pwm dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_stb_i (stb_i),
        .wbs_cyc_i (cyc_i),
        .wbs_we_i  (we_i),
        .wbs_sel_i (sel_i),
        .wbs_adr_i (adr_i),
        .wbs_dat_i (dat_i),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .pwm_o     (pwm),
        .pwm_oeb_o (oeb),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; leaves one idle cycle before returning.
    task automatic bus(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        int n;
        stb_i = 1'b1; cyc_i = 1'b1; we_i = w;
        adr_i = a; dat_i = d; sel_i = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack !== 1'b1 && n < 8);
        last_lat = n;
        last_cyc = ncyc;
        last_rd  = dat_r;
        tests++;
        if (ack !== 1'b1) begin
            fails++;
            $display("FAIL bus_ack adr=%h ack=%b want 1", a, ack);
        end
        stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] o, input logic [31:0] d);
        bus(1'b1, BASE + o, d, 4'hF);
    endtask

    task automatic rd(input logic [31:0] o);
        bus(1'b0, BASE + o, 32'h0, 4'hF);
    endtask

    task automatic test_reset();
        #2;
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rst_ack got %b want 0", ack); end
        tests++; if (dat_r !== 32'h0) begin fails++; $display("FAIL rst_dat got %h want 0", dat_r); end
        tests++; if (pwm !== 1'b0) begin fails++; $display("FAIL rst_pwm got %b want 0", pwm); end
        tests++; if (oeb !== 1'b1) begin fails++; $display("FAIL rst_oeb got %b want 1", oeb); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq got %b want 0", irq); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rd(32'(i * 4));
            tests++;
            if (last_rd !== 32'h0) begin
                fails++;
                $display("FAIL rst_read off=%0d got %h want 0", i * 4, last_rd);
            end
            tests++;
            if (last_lat != 1) begin
                fails++;
                $display("FAIL ack_latency got %0d want 1", last_lat);
            end
        end
        tests++; if (oeb !== 1'b1) begin fails++; $display("FAIL idle_oeb got %b want 1", oeb); end
    endtask

    task automatic test_held_strobe();
        logic e;
        stb_i = 1'b1; cyc_i = 1'b1; we_i = 1'b0;
        adr_i = BASE + O_PER; sel_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = (i % 2 == 0);
            tests++;
            if (ack !== e) begin
                fails++;
                $display("FAIL held_ack i=%0d got %b want %b", i, ack, e);
            end
            tests++;
            if (!ack && dat_r !== 32'h0) begin
                fails++;
                $display("FAIL dat_idle i=%0d got %h want 0", i, dat_r);
            end
        end
        stb_i = 1'b0; cyc_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_regs();
        logic [31:0] old;
        logic [31:0] nv;
        logic [31:0] msk;
        logic [31:0] exp;
        logic [31:0] o;
        logic [3:0]  s;
        logic [31:0] cmask;
        for (int i = 0; i < 8; i++) begin
            o = (i % 2 == 0) ? O_PER : O_DUTY;
            old = $urandom & 32'hFFFF;
            nv  = $urandom;
            s   = 4'($urandom_range(0, 15));
            msk = 32'h0;
            for (int b = 0; b < 4; b++)
                if (s[b]) msk[8*b +: 8] = 8'hFF;
            exp = ((old & ~msk) | (nv & msk)) & 32'hFFFF;
            wr(o, old);
            bus(1'b1, BASE + o, nv, s);
            rd(o);
            tests++;
            if (last_rd !== exp) begin
                fails++;
                $display("FAIL lanes off=%h sel=%h got %h want %h", o, s, last_rd, exp);
            end
        end
        wr(32'h14, $urandom);
        rd(32'h14);
        tests++; if (last_rd !== 32'h0) begin fails++; $display("FAIL unmapped got %h want 0", last_rd); end
        wr(O_CNT, 32'h1234);
        rd(O_CNT);
        tests++; if (last_rd !== 32'h0) begin fails++; $display("FAIL count_ro got %h want 0", last_rd); end
`ifdef PWM_IRQ_EN
        cmask = 32'h7;
`else
        cmask = 32'h3;
`endif
        wr(O_CTRL, 32'h6);
        rd(O_CTRL);
        tests++;
        if (last_rd !== (32'h6 & cmask)) begin
            fails++;
            $display("FAIL ctrl_rb got %h want %h", last_rd, 32'h6 & cmask);
        end
        wr(O_STAT, 32'h1);
        rd(O_STAT);
        tests++; if (last_rd !== 32'h0) begin fails++; $display("FAIL stat_idle got %h want 0", last_rd); end
        wr(O_CTRL, 32'h0);
    endtask

    // Enable with (p,d,pol); at edge e+m write nv to PERIOD or DUTY.
    task automatic run_case(input int p, input int d, input bit pol,
                            input int m, input bit chg_per, input int nv);
        int e;
        int n;
        int k;
        int pp;
        int dd;
        int p2;
        int d2;
        p2 = chg_per ? nv : p;
        d2 = chg_per ? d : nv;
        wr(O_PER, 32'(p));
        wr(O_DUTY, 32'(d));
        wr(O_CTRL, {30'b0, pol, 1'b1});
        e = last_cyc;
        n = m + 2 * (p + 1) + 2 * (p2 + 1) + 8;
        k = 0;
        while (k <= n + 1) begin
            pp = (k > m) ? p2 : p;
            dd = (k > m) ? d2 : d;
            for (int j = 0; j <= pp; j++) begin
                ecnt[k + j]  = j;
                eduty[k + j] = dd;
            end
            k += pp + 1;
        end
        fork
            begin
                int kk;
                logic ep;
                while (ncyc - e <= n) begin
                    kk = ncyc - e;
                    ep = (ecnt[kk - 1] < eduty[kk - 1]) ^ pol;
                    tests++;
                    if (pwm !== ep) begin
                        fails++;
                        $display("FAIL pwm p=%0d d=%0d pol=%0d k=%0d got %b want %b",
                                 p, d, pol, kk, pwm, ep);
                    end
                    tests++;
                    if (oeb !== 1'b0) begin
                        fails++;
                        $display("FAIL run_oeb k=%0d got %b want 0", kk, oeb);
                    end
                    @(negedge clk);
                end
            end
            begin
                int idx;
                while (ncyc < e + m - 1) @(negedge clk);
                wr(chg_per ? O_PER : O_DUTY, 32'(nv));
                rd(O_CNT);
                idx = last_cyc - 1 - e;
                tests++;
                if (last_rd !== 32'(ecnt[idx])) begin
                    fails++;
                    $display("FAIL count_rd idx=%0d got %0d want %0d", idx, last_rd, ecnt[idx]);
                end
            end
        join
        wr(O_CTRL, {30'b0, pol, 1'b0});
        tests++; if (pwm !== pol) begin fails++; $display("FAIL off_pwm got %b want %b", pwm, pol); end
        tests++; if (oeb !== 1'b1) begin fails++; $display("FAIL off_oeb got %b want 1", oeb); end
        rd(O_CNT);
        tests++; if (last_rd !== 32'h0) begin fails++; $display("FAIL off_count got %h want 0", last_rd); end
    endtask

    task automatic test_pwm_basic();
        run_case(9, 3, 1'b0, 30, 1'b0, 3);
        run_case(9, 3, 1'b0, 4, 1'b0, 8);
        run_case(9, 0, 1'b1, 2, 1'b0, 20);
        run_case(0, 1, 1'b0, 2, 1'b0, 0);
        run_case(5, 2, 1'b0, 6, 1'b1, 3);
    endtask

    task automatic test_random();
        int p;
        int d;
        int m;
        bit pol;
        bit chg;
        int nv;
        for (int i = 0; i < 8; i++) begin
            p   = $urandom_range(1, 12);
            d   = $urandom_range(0, p + 3);
            pol = 1'($urandom_range(0, 1));
            chg = 1'($urandom_range(0, 1));
            m   = $urandom_range(2, p + 3);
            nv  = chg ? $urandom_range(0, 12) : $urandom_range(0, 14);
            run_case(p, d, pol, m, chg, nv);
        end
    endtask

    task automatic test_irq();
        logic ei;
`ifdef PWM_IRQ_EN
        int e;
        int kk;
        wr(O_PER, 32'd4);
        wr(O_CTRL, 32'h5);
        e = last_cyc;
        while (ncyc - e <= 5) begin
            kk = ncyc - e;
            ei = (kk >= 5);
            tests++;
            if (irq !== ei) begin fails++; $display("FAIL irq_rise k=%0d got %b want %b", kk, irq, ei); end
            @(negedge clk);
        end
        wr(O_STAT, 32'h1);
        while (ncyc - e <= 12) begin
            kk = ncyc - e;
            ei = (kk >= 10);
            tests++;
            if (irq !== ei) begin fails++; $display("FAIL irq_clr k=%0d got %b want %b", kk, irq, ei); end
            @(negedge clk);
        end
        rd(O_STAT);
        tests++; if (last_rd !== 32'h1) begin fails++; $display("FAIL stat_set got %h want 1", last_rd); end
        wr(O_CTRL, 32'h0);
        wr(O_STAT, 32'h1);
        rd(O_STAT);
        tests++; if (last_rd !== 32'h0) begin fails++; $display("FAIL stat_w1c got %h want 0", last_rd); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_end got %b want 0", irq); end
`else
        wr(O_PER, 32'd1);
        wr(O_CTRL, 32'h5);
        ei = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (irq !== ei) begin fails++; $display("FAIL irq_tied i=%0d got %b want 0", i, irq); end
        end
        wr(O_STAT, 32'h1);
        rd(O_STAT);
        tests++; if (last_rd !== 32'h0) begin fails++; $display("FAIL stat_absent got %h want 0", last_rd); end
        rd(O_CTRL);
        tests++; if (last_rd !== 32'h1) begin fails++; $display("FAIL ctrl_absent got %h want 1", last_rd); end
        wr(O_CTRL, 32'h0);
`endif
    endtask

    task automatic test_unselected();
        wr(O_PER, 32'h21);
        stb_i = 1'b1; cyc_i = 1'b1; we_i = 1'b1;
        adr_i = BASE + 32'h104; dat_i = 32'h77; sel_i = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (ack !== 1'b0) begin fails++; $display("FAIL unsel_ack i=%0d got %b want 0", i, ack); end
        end
        stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
        @(negedge clk);
        rd(O_PER);
        tests++; if (last_rd !== 32'h21) begin fails++; $display("FAIL unsel_per got %h want 21", last_rd); end
    endtask

    task automatic test_reset_midrun();
        wr(O_PER, 32'd9);
        wr(O_DUTY, 32'd5);
        wr(O_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        stb_i = 1'b1; cyc_i = 1'b1; we_i = 1'b1;
        adr_i = BASE + O_PER; dat_i = 32'h55; sel_i = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (pwm !== 1'b0) begin fails++; $display("FAIL mid_pwm got %b want 0", pwm); end
        tests++; if (oeb !== 1'b1) begin fails++; $display("FAIL mid_oeb got %b want 1", oeb); end
        @(negedge clk);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL mid_ack got %b want 0", ack); end
        stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        rd(O_CNT);
        tests++; if (last_rd !== 32'h0) begin fails++; $display("FAIL mid_cnt got %h want 0", last_rd); end
        rd(O_PER);
        tests++; if (last_rd !== 32'h0) begin fails++; $display("FAIL mid_per got %h want 0", last_rd); end
        rd(O_CTRL);
        tests++; if (last_rd !== 32'h0) begin fails++; $display("FAIL mid_ctrl got %h want 0", last_rd); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
        sel_i = 4'h0; adr_i = 32'h0; dat_i = 32'h0;
        test_reset();
        test_held_strobe();
        test_regs();
        test_pwm_basic();
        test_random();
        test_irq();
        test_unselected();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
